// File: rtl/display_mux_pwm.sv
`default_nettype none
// ============================================================================
// display_mux_pwm : scanned 7-segment driver with per-slot brightness PWM
// Revision 1.0
// ============================================================================
module display_mux_pwm #(
  parameter int DIGITS         = 4,
  parameter int DWELL_W        = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   decs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DWELL_W-1:0]    brightness,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [7:0]            segments,
  output logic [DIGITS-1:0]     digits,
  output logic                  frame_tick
);

  localparam int                 IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DWELL_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [7:0]         SEG_OFF  = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0]  DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW}};

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               frame_tick_q, frame_tick_d;
  logic [7:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  dig_q, dig_d;

  logic [DIGITS-1:0]  lz;
  logic               zero_above;
  logic [3:0]         nib;
  logic               dp;
  logic               blank;
  logic [DIGITS-1:0]  onehot;
  logic               lit;
  logic [6:0]         a2g;

  function automatic logic [6:0] decode7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hF:    s = 7'b0000000;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    frame_tick_d = 1'b0;
    if (cnt_q == CNT_MAX) begin
      if (idx_q == IDX_LAST) begin
        idx_d        = '0;
        frame_tick_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // lz[k] is set when nibble k and every nibble above it are zero
    zero_above = 1'b1;
    lz         = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (decs[4*k +: 4] == 4'h0);
      lz[k]      = zero_above;
    end

    nib    = 4'h0;
    dp     = 1'b0;
    blank  = 1'b0;
    onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib       = decs[4*k +: 4];
        dp        = points[k];
        blank     = blank_lz && (k != 0) && lz[k];
        onehot[k] = 1'b1;
      end
    end

    // cnt==0 is a forced dark clock so the previous digit never ghosts
    lit   = enable && (cnt_q != '0) && (cnt_q <= brightness);
    a2g   = blank ? 7'b0000000 : decode7(nib);
    seg_d = lit ? ({a2g, dp} ^ SEG_OFF) : SEG_OFF;
    dig_d = lit ? (onehot ^ DIG_OFF)    : DIG_OFF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign segments   = seg_q;
  assign digits     = dig_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_display_mux_pwm.sv
`default_nettype none
// ============================================================================
// tb_display_mux_pwm : two display_mux_pwm instances checked against a
// cycle-count reference model. Revision 1.0
// ============================================================================
module tb_display_mux_pwm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        blank_lz;
  logic        enable;
  logic [15:0] decs_a;
  logic [3:0]  points_a;
  logic [3:0]  bright_a;
  logic [23:0] decs_b;
  logic [5:0]  points_b;
  logic [2:0]  bright_b;

  logic [7:0]  seg_a, seg_b;
  logic [3:0]  dig_a;
  logic [5:0]  dig_b;
  logic        tick_a, tick_b;

  int checks = 0;
  int errors = 0;
  int n      = 0;   // counting edges since the last reset edge
  int mode   = 0;   // 0 hold, 1 random enable, 2 fully random

  logic [7:0] exp_seg_a, exp_seg_b;
  logic [5:0] exp_dig_a, exp_dig_b;
  logic       exp_tick_a, exp_tick_b;

  display_mux_pwm #(.DIGITS(4), .DWELL_W(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .decs(decs_a), .points(points_a), .brightness(bright_a),
    .blank_lz(blank_lz), .enable(enable), .segments(seg_a), .digits(dig_a), .frame_tick(tick_a)
  );

  display_mux_pwm #(.DIGITS(6), .DWELL_W(3), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .decs(decs_b), .points(points_b), .brightness(bright_b),
    .blank_lz(blank_lz), .enable(enable), .segments(seg_b), .digits(dig_b), .frame_tick(tick_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at n=%0d t=%0t", tag, obs, exp, n, $time);
    end
  endtask

  function automatic logic [6:0] seg7(input int v);
    case (v)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011; 15: return 7'b0000000;
      default: return 7'b0000001;
    endcase
  endfunction

  // Output expected one edge after a state with n counting edges since reset.
  function automatic void model(input int d, input int w, input bit sal, input bit dal,
                                input int cyc, input logic [23:0] dv, input logic [5:0] pv,
                                input int br, input bit blz, input bit en, input bit rst,
                                output logic [7:0] seg, output logic [5:0] dig, output logic tick);
    int p    = 1 << w;
    int cnt  = cyc % p;
    int idx  = (cyc / p) % d;
    int mask = (1 << d) - 1;
    int upper;
    logic [6:0] a2g;
    seg  = {8{sal}};
    dig  = dal ? 6'(mask) : 6'd0;
    tick = 1'b0;
    if (rst) return;
    tick = (cnt == p - 1) && (idx == d - 1);
    if (en && cnt >= 1 && cnt <= br) begin
      upper = int'(dv >> (4 * idx));
      a2g   = seg7(upper % 16);
      if (blz && idx >= 1 && upper == 0) a2g = 7'b0;
      seg = {a2g, pv[idx]} ^ {8{sal}};
      dig = 6'(1 << idx) ^ (dal ? 6'(mask) : 6'd0);
    end
  endfunction

  function automatic logic [23:0] rand_decs(input int d);
    logic [23:0] v = '0;
    for (int k = 0; k < d; k++)
      if ($urandom_range(1, 0) == 1) v[4*k +: 4] = 4'($urandom_range(15, 0));
    return v;
  endfunction

  task automatic stim();
    if (mode >= 1 && $urandom_range(7, 0) == 0) enable = ~enable;
    if (mode == 2) begin
      rst_n = ($urandom_range(99, 0) != 0);
      if ($urandom_range(3, 0) == 0) begin
        bright_a = 4'($urandom_range(15, 0));
        bright_b = 3'($urandom_range(7, 0));
      end
      if ($urandom_range(15, 0) == 0) begin
        decs_a   = 16'(rand_decs(4));
        decs_b   = rand_decs(6);
        points_a = 4'($urandom_range(15, 0));
        points_b = 6'($urandom_range(63, 0));
        blank_lz = 1'($urandom_range(1, 0));
      end
    end
  endtask

  task automatic run(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      stim();
      model(4, 4, 1'b0, 1'b0, n, {8'h0, decs_a}, {2'b0, points_a}, int'(bright_a),
            blank_lz, enable, !rst_n, exp_seg_a, exp_dig_a, exp_tick_a);
      model(6, 3, 1'b1, 1'b1, n, decs_b, points_b, int'(bright_b),
            blank_lz, enable, !rst_n, exp_seg_b, exp_dig_b, exp_tick_b);
      n = rst_n ? n + 1 : 0;
      @(posedge clk);
      @(negedge clk);
      chk("seg_a",  32'(seg_a),  32'(exp_seg_a));
      chk("dig_a",  32'(dig_a),  32'(exp_dig_a[3:0]));
      chk("tick_a", 32'(tick_a), 32'(exp_tick_a));
      chk("seg_b",  32'(seg_b),  32'(exp_seg_b));
      chk("dig_b",  32'(dig_b),  32'(exp_dig_b));
      chk("tick_b", 32'(tick_b), 32'(exp_tick_b));
      chk("onehot_a", 32'($countones(dig_a) <= 1), 32'd1);
      chk("onehot_b", 32'($countones(~dig_b) <= 1), 32'd1);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    blank_lz = 1'b0;
    decs_a   = 16'h1234;  points_a = 4'b0001;   bright_a = 4'd15;
    decs_b   = 24'h123456; points_b = 6'b000001; bright_b = 3'd7;
    mode     = 0;

    run(3);
    chk("rst_seg_a", 32'(seg_a), 32'h00);
    chk("rst_dig_a", 32'(dig_a), 32'h0);
    chk("rst_seg_b", 32'(seg_b), 32'hFF);
    chk("rst_dig_b", 32'(dig_b), 32'h3F);

    rst_n = 1'b1;
    run(1);
    chk("first_dark_a", 32'(dig_a), 32'h0);
    run(1);
    chk("first_lit_dig_a", 32'(dig_a), 32'h1);
    chk("first_lit_seg_a", 32'(seg_a), 32'h67);
    chk("first_lit_dig_b", 32'(dig_b), 32'h3E);
    run(200);

    bright_a = 4'd4;  bright_b = 3'd4;  run(128);
    bright_a = 4'd0;  bright_b = 3'd0;  run(128);

    bright_a = 4'd15; bright_b = 3'd7;
    decs_a = 16'h0005; decs_b = 24'h000005; blank_lz = 1'b1; run(128);
    blank_lz = 1'b0; run(128);

    decs_a = 16'hFA09; decs_b = 24'h00FA09; blank_lz = 1'b1; run(128);

    mode = 1;
    run(200);
    for (int g = 0; g < 70 && (n % 64) != 39; g++) run(1);
    chk("reach_idx2_cnt7", 32'(n % 64), 32'd39);
    mode = 0; enable = 1'b1; bright_a = 4'd9; bright_b = 3'd5;
    rst_n = 1'b0; run(2);
    chk("midrst_dig_a", 32'(dig_a), 32'h0);
    chk("midrst_seg_a", 32'(seg_a), 32'h00);
    rst_n = 1'b1; run(1);
    chk("post_rst_dark_a", 32'(dig_a), 32'h0);
    run(1);
    chk("post_rst_lit_a", 32'(dig_a), 32'h1);
    chk("post_rst_lit_b", 32'(dig_b), 32'h3E);

    mode = 2;
    run(2500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
